// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Brief    : Requester, response and adder-side bundle for adder_arbiter.
// Revision : 1.0
// ============================================================================
interface adder_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [31:0] req0_x_i;
    logic [31:0] req0_y_i;
    logic        req0_sub_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [31:0] req1_x_i;
    logic [31:0] req1_y_i;
    logic        req1_sub_i;

    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [31:0] rsp_z_o;
    logic        rsp_inf_o;
    logic        rsp_nan_o;
    logic        rsp_err_o;

    logic        add_valid_o;
    logic        add_x_sign_o;
    logic [7:0]  add_x_exp_o;
    logic [22:0] add_x_frac_o;
    logic        add_y_sign_o;
    logic [7:0]  add_y_exp_o;
    logic [22:0] add_y_frac_o;
    logic        add_x_greater_o;
    logic [7:0]  add_exp_shift_o;
    logic        add_infinity_o;
    logic        add_nan_o;
    logic        add_valid_i;
    logic [31:0] add_z_i;
    logic        add_infinity_i;
    logic        add_nan_i;

    modport slave (
        input  req0_valid_i, req0_x_i, req0_y_i, req0_sub_i,
        input  req1_valid_i, req1_x_i, req1_y_i, req1_sub_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_z_o, rsp_inf_o, rsp_nan_o, rsp_err_o,
        output add_valid_o, add_x_sign_o, add_x_exp_o, add_x_frac_o,
        output add_y_sign_o, add_y_exp_o, add_y_frac_o,
        output add_x_greater_o, add_exp_shift_o, add_infinity_o, add_nan_o,
        input  add_valid_i, add_z_i, add_infinity_i, add_nan_i
    );

    modport master (
        output req0_valid_i, req0_x_i, req0_y_i, req0_sub_i,
        output req1_valid_i, req1_x_i, req1_y_i, req1_sub_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_z_o, rsp_inf_o, rsp_nan_o, rsp_err_o,
        input  add_valid_o, add_x_sign_o, add_x_exp_o, add_x_frac_o,
        input  add_y_sign_o, add_y_exp_o, add_y_frac_o,
        input  add_x_greater_o, add_exp_shift_o, add_infinity_o, add_nan_o,
        output add_valid_i, add_z_i, add_infinity_i, add_nan_i
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin front end sharing one FP32 adder between two requesters.
// Revision : 1.0
// ============================================================================
module adder_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    adder_arbiter_if.slave    bus
);

    localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
    localparam logic [7:0]  c_tmo_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_last_grant;
    logic        r_id;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [7:0]  r_cnt;
    logic        r_rsp_id;
    logic [31:0] r_rsp_z;
    logic        r_rsp_inf;
    logic        r_rsp_nan;
    logic        r_rsp_err;

    logic        w_grant;
    logic        w_idle;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [31:0] w_in_x;
    logic [31:0] w_in_y;
    logic        w_x_nan, w_x_inf, w_y_nan, w_y_inf;
    logic        w_byp_nan, w_bypass;
    logic [31:0] w_byp_z;
    logic        w_timeout;
    logic        w_busy;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_grant = bus.req1_valid_i;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            w_grant = ~r_last_grant;
        end
    end

    assign w_idle   = (r_state == S_IDLE) && !rst_i;
    assign w_ready0 = w_idle && !w_grant && bus.req0_valid_i;
    assign w_ready1 = w_idle &&  w_grant && bus.req1_valid_i;
    assign w_accept = w_ready0 || w_ready1;
    assign bus.req0_ready_o = w_ready0;
    assign bus.req1_ready_o = w_ready1;

    // y carries the effective sign: subtraction is folded into an add of -y.
    assign w_in_x = w_grant ? bus.req1_x_i : bus.req0_x_i;
    assign w_in_y = w_grant ? {bus.req1_y_i[31] ^ bus.req1_sub_i, bus.req1_y_i[30:0]}
                            : {bus.req0_y_i[31] ^ bus.req0_sub_i, bus.req0_y_i[30:0]};

    assign w_x_nan   = (&w_in_x[30:23]) &&  (|w_in_x[22:0]);
    assign w_x_inf   = (&w_in_x[30:23]) && !(|w_in_x[22:0]);
    assign w_y_nan   = (&w_in_y[30:23]) &&  (|w_in_y[22:0]);
    assign w_y_inf   = (&w_in_y[30:23]) && !(|w_in_y[22:0]);
    assign w_byp_nan = w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_in_x[31] != w_in_y[31]));
    assign w_bypass  = w_byp_nan || w_x_inf || w_y_inf;
    assign w_byp_z   = w_byp_nan ? c_qnan : (w_x_inf ? w_in_x : w_in_y);

    assign w_timeout = (r_state == S_WAIT) && !bus.add_valid_i && (r_cnt == c_tmo_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_bypass ? S_RESPOND : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.add_valid_i || w_timeout) begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_cnt        <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_z      <= '0;
            r_rsp_inf    <= 1'b0;
            r_rsp_nan    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x          <= w_in_x;
                r_y          <= w_in_y;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            // Response fields load only on entry to RESPOND and hold afterwards.
            if (w_accept && w_bypass) begin
                r_rsp_id  <= w_grant;
                r_rsp_z   <= w_byp_z;
                r_rsp_inf <= !w_byp_nan;
                r_rsp_nan <= w_byp_nan;
                r_rsp_err <= 1'b0;
            end else if ((r_state == S_WAIT) && bus.add_valid_i) begin
                r_rsp_id  <= r_id;
                r_rsp_z   <= bus.add_z_i;
                r_rsp_inf <= bus.add_infinity_i;
                r_rsp_nan <= bus.add_nan_i;
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_id  <= r_id;
                r_rsp_z   <= '0;
                r_rsp_inf <= 1'b0;
                r_rsp_nan <= 1'b0;
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Operand fields are shown to the adder only while it owns the operation.
    always_comb begin
        bus.add_x_sign_o    = 1'b0;
        bus.add_x_exp_o     = '0;
        bus.add_x_frac_o    = '0;
        bus.add_y_sign_o    = 1'b0;
        bus.add_y_exp_o     = '0;
        bus.add_y_frac_o    = '0;
        bus.add_x_greater_o = 1'b0;
        bus.add_exp_shift_o = '0;
        bus.add_infinity_o  = 1'b0;
        bus.add_nan_o       = 1'b0;
        if (w_busy) begin
            bus.add_x_sign_o    = r_x[31];
            bus.add_x_exp_o     = r_x[30:23];
            bus.add_x_frac_o    = r_x[22:0];
            bus.add_y_sign_o    = r_y[31];
            bus.add_y_exp_o     = r_y[30:23];
            bus.add_y_frac_o    = r_y[22:0];
            bus.add_x_greater_o = (r_x[30:23] > r_y[30:23]) ||
                                  ((r_x[30:23] == r_y[30:23]) && (r_x[22:0] >= r_y[22:0]));
            bus.add_exp_shift_o = (r_x[30:23] > r_y[30:23]) ? (r_x[30:23] - r_y[30:23])
                                                            : (r_y[30:23] - r_x[30:23]);
            bus.add_nan_o       = ((&r_x[30:23]) && (|r_x[22:0])) ||
                                  ((&r_y[30:23]) && (|r_y[22:0]));
            bus.add_infinity_o  = ((&r_x[30:23]) && !(|r_x[22:0])) ||
                                  ((&r_y[30:23]) && !(|r_y[22:0]));
        end
    end

    assign bus.add_valid_o = (r_state == S_ISSUE);
    assign bus.rsp_valid_o = (r_state == S_RESPOND);
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_z_o     = r_rsp_z;
    assign bus.rsp_inf_o   = r_rsp_inf;
    assign bus.rsp_nan_o   = r_rsp_nan;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Directed self-checking bench for adder_arbiter.
// Revision : 1.0
// ============================================================================
module tb_adder_arbiter;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fails  = 0;

    adder_arbiter_if bus ();

    adder_arbiter #(.TIMEOUT(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
    endtask

    task automatic drive_req(input int port, input logic [31:0] x, input logic [31:0] y,
                             input logic sub);
        clear_reqs();
        if (port == 0) begin
            bus.req0_valid_i = 1'b1; bus.req0_x_i = x; bus.req0_y_i = y; bus.req0_sub_i = sub;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_x_i = x; bus.req1_y_i = y; bus.req1_sub_i = sub;
        end
    endtask

    task automatic adder_reply(input logic [31:0] z, input logic inf, input logic nan);
        bus.add_valid_i = 1'b1; bus.add_z_i = z; bus.add_infinity_i = inf; bus.add_nan_i = nan;
        tick();
        bus.add_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        int g;
        rst_i = 1'b1;
        clear_reqs();
        bus.req0_x_i = '0; bus.req0_y_i = '0; bus.req0_sub_i = 1'b0;
        bus.req1_x_i = '0; bus.req1_y_i = '0; bus.req1_sub_i = 1'b0;
        bus.add_valid_i = 1'b0; bus.add_z_i = '0; bus.add_infinity_i = 1'b0; bus.add_nan_i = 1'b0;

        // Reset state, with a request pending to prove ready is held low.
        drive_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        tick(); tick();
        check_val("rst_ready0",   bus.req0_ready_o,    0);
        check_val("rst_rsp_valid", bus.rsp_valid_o,    0);
        check_val("rst_add_valid", bus.add_valid_o,    0);
        check_val("rst_rsp_z",    bus.rsp_z_o,         0);
        check_val("rst_xgreater", bus.add_x_greater_o, 0);
        rst_i = 1'b0;

        // 1.0 + 1.0 on port 0
        #1;
        check_val("p0_ready0", bus.req0_ready_o, 1);
        check_val("p0_ready1", bus.req1_ready_o, 0);
        tick();
        clear_reqs();
        check_val("p0_add_valid", bus.add_valid_o,     1);
        check_val("p0_xgreater",  bus.add_x_greater_o, 1);
        check_val("p0_shift",     bus.add_exp_shift_o, 0);
        check_val("p0_xexp",      bus.add_x_exp_o,     8'h7F);
        tick();
        check_val("p0_add_pulse", bus.add_valid_o, 0);
        check_val("p0_xexp_hold", bus.add_x_exp_o, 8'h7F);
        adder_reply(32'h4000_0000, 1'b0, 1'b0);
        check_val("p0_rsp_valid", bus.rsp_valid_o, 1);
        check_val("p0_rsp_z",     bus.rsp_z_o,     32'h4000_0000);
        check_val("p0_rsp_id",    bus.rsp_id_o,    0);
        check_val("p0_rsp_err",   bus.rsp_err_o,   0);
        tick();
        check_val("p0_rsp_pulse", bus.rsp_valid_o, 0);
        check_val("p0_rsp_hold",  bus.rsp_z_o,     32'h4000_0000);

        // Round robin: fresh reset, both requesters continuously valid.
        rst_i = 1'b1; #1; rst_i = 1'b0;
        bus.req0_valid_i = 1'b1; bus.req0_x_i = 32'h3F80_0000; bus.req0_y_i = 32'h4000_0000; bus.req0_sub_i = 1'b0;
        bus.req1_valid_i = 1'b1; bus.req1_x_i = 32'h4000_0000; bus.req1_y_i = 32'h3F80_0000; bus.req1_sub_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            #1;
            check_val($sformatf("rr%0d_ready0", k), bus.req0_ready_o, (g == 0) ? 1 : 0);
            check_val($sformatf("rr%0d_ready1", k), bus.req1_ready_o, (g == 1) ? 1 : 0);
            tick();
            check_val($sformatf("rr%0d_busy_ready", k), bus.req0_ready_o | bus.req1_ready_o, 0);
            check_val($sformatf("rr%0d_add_valid", k), bus.add_valid_o, 1);
            check_val($sformatf("rr%0d_xgreater", k), bus.add_x_greater_o, g);
            check_val($sformatf("rr%0d_ysign", k), bus.add_y_sign_o, g);
            check_val($sformatf("rr%0d_shift", k), bus.add_exp_shift_o, 1);
            tick();
            adder_reply((g == 1) ? 32'h3F80_0000 : 32'h4040_0000, 1'b0, 1'b0);
            check_val($sformatf("rr%0d_rsp_valid", k), bus.rsp_valid_o, 1);
            check_val($sformatf("rr%0d_rsp_id", k), bus.rsp_id_o, g);
            check_val($sformatf("rr%0d_rsp_z", k), bus.rsp_z_o, (g == 1) ? 32'h3F80_0000 : 32'h4040_0000);
            tick();
        end
        clear_reqs();

        // NaN operand on port 1 bypasses the adder.
        drive_req(1, 32'h7FC0_0001, 32'h3F80_0000, 1'b0);
        #1;
        check_val("nan_ready1", bus.req1_ready_o, 1);
        tick();
        clear_reqs();
        check_val("nan_rsp_valid", bus.rsp_valid_o, 1);
        check_val("nan_add_valid", bus.add_valid_o, 0);
        check_val("nan_z",   bus.rsp_z_o,   32'h7FC0_0000);
        check_val("nan_nan", bus.rsp_nan_o, 1);
        check_val("nan_inf", bus.rsp_inf_o, 0);
        check_val("nan_id",  bus.rsp_id_o,  1);
        tick();

        // Inf - Inf -> NaN
        drive_req(0, 32'h7F80_0000, 32'h7F80_0000, 1'b1);
        tick(); clear_reqs();
        check_val("imi_rsp_valid", bus.rsp_valid_o, 1);
        check_val("imi_z",   bus.rsp_z_o,   32'h7FC0_0000);
        check_val("imi_nan", bus.rsp_nan_o, 1);
        tick();

        // Inf + Inf -> Inf
        drive_req(0, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
        tick(); clear_reqs();
        check_val("ipi_rsp_valid", bus.rsp_valid_o, 1);
        check_val("ipi_z",   bus.rsp_z_o,   32'h7F80_0000);
        check_val("ipi_inf", bus.rsp_inf_o, 1);
        check_val("ipi_nan", bus.rsp_nan_o, 0);
        tick();

        // 1.0 - (+Inf) -> -Inf
        drive_req(0, 32'h3F80_0000, 32'h7F80_0000, 1'b1);
        tick(); clear_reqs();
        check_val("omi_z",   bus.rsp_z_o,   32'hFF80_0000);
        check_val("omi_inf", bus.rsp_inf_o, 1);
        tick();

        // Timeout: adder never answers.
        drive_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        tick(); clear_reqs();
        check_val("tmo_add_valid", bus.add_valid_o, 1);
        n = 0;
        while (!bus.rsp_valid_o && n < 40) begin
            tick();
            n++;
        end
        check_val("tmo_cycles", n, 17);
        check_val("tmo_err", bus.rsp_err_o, 1);
        check_val("tmo_z",   bus.rsp_z_o,   0);
        check_val("tmo_id",  bus.rsp_id_o,  0);
        tick();
        adder_reply(32'h4000_0000, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            pulses += int'(bus.rsp_valid_o);
            tick();
        end
        check_val("late_pulses", pulses, 0);
        check_val("late_err_hold", bus.rsp_err_o, 1);

        // Result arriving on the final WAIT cycle beats the timeout.
        drive_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        tick(); clear_reqs();
        for (int k = 0; k < 16; k++) tick();
        adder_reply(32'h4000_0000, 1'b0, 1'b0);
        check_val("edge_rsp_valid", bus.rsp_valid_o, 1);
        check_val("edge_err", bus.rsp_err_o, 0);
        check_val("edge_z",   bus.rsp_z_o,   32'h4000_0000);
        tick();

        // Asynchronous reset in the middle of WAIT.
        drive_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        tick(); clear_reqs();
        tick();
        check_val("arst_pre_xexp", bus.add_x_exp_o, 8'h7F);
        #2 rst_i = 1'b1;
        #1;
        check_val("arst_xexp",  bus.add_x_exp_o, 0);
        check_val("arst_rsp_z", bus.rsp_z_o,     0);
        #2 rst_i = 1'b0;
        pulses = 0;
        tick();
        pulses += int'(bus.rsp_valid_o);
        adder_reply(32'h4000_0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            pulses += int'(bus.rsp_valid_o);
            tick();
        end
        check_val("arst_pulses", pulses, 0);

        drive_req(1, 32'h4000_0000, 32'h4000_0000, 1'b0);
        #1;
        check_val("post_ready1", bus.req1_ready_o, 1);
        tick(); clear_reqs();
        check_val("post_add_valid", bus.add_valid_o, 1);
        tick();
        adder_reply(32'h4080_0000, 1'b0, 1'b0);
        check_val("post_rsp_valid", bus.rsp_valid_o, 1);
        check_val("post_rsp_id", bus.rsp_id_o, 1);
        check_val("post_rsp_z",  bus.rsp_z_o,  32'h4080_0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
